// File: rtl/me_frame_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : me_pkg
//  Description : Constants and types shared by the frame loader and the
//                motion-estimation engine it feeds.
//  Revision    : 1.0 - initial release
// ============================================================================
package me_pkg;

    localparam int DATA_W    = 64;   // one stream / buffer word (8 pixels x 8 bits)
    localparam int CUR_AW    = 5;    // current-buffer address width
    localparam int REF_AW    = 7;    // reference-buffer address width
    localparam int CUR_WORDS = 32;   // words per current block (<= 2**CUR_AW)
    localparam int REF_WORDS = 128;  // words per reference window (<= 2**REF_AW)

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD_CUR = 2'd1,
        LOAD_REF = 2'd2,
        DONE     = 2'd3
    } loader_state_e;

    typedef logic [DATA_W-1:0] pix_word_t;

endpackage
`default_nettype wire

// File: rtl/me_frame_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : me_frame_loader_if
//  Description : Valid/ready pixel-word stream into the frame loader.
//                master = stream source, slave = loader.
//  Revision    : 1.0 - initial release
// ============================================================================
interface me_frame_loader_if;
    import me_pkg::*;

    pix_word_t in_data;
    logic      in_valid;
    logic      in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);

endinterface
`default_nettype wire

// File: rtl/me_frame_loader_wr_port.sv
`default_nettype none
// ============================================================================
//  Module      : me_wr_port
//  Description : Registered write stage for one engine buffer. A request in
//                cycle N becomes a one-cycle strobe in cycle N+1; address and
//                data hold their last values while the strobe is low.
//  Revision    : 1.0 - initial release
// ============================================================================
module me_wr_port #(
    parameter int AW = 5,
    parameter int DW = 64
) (
    input  wire           clk,
    input  wire           reset,
    input  wire           wr_en,
    input  wire  [AW-1:0] wr_addr,
    input  wire  [DW-1:0] wr_data,
    output logic [AW-1:0] address,
    output logic [DW-1:0] data,
    output logic          write_enable
);

    logic [AW-1:0] address_d, address_q;
    logic [DW-1:0] data_d, data_q;
    logic          write_enable_d, write_enable_q;

    // Capture a new address/data only on a request, otherwise hold
    always_comb begin
        address_d      = address_q;
        data_d         = data_q;
        write_enable_d = wr_en;
        if (wr_en) begin
            address_d = wr_addr;
            data_d    = wr_data;
        end
    end

    // Output register stage, cleared by the active-low synchronous reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            address_q      <= '0;
            data_q         <= '0;
            write_enable_q <= 1'b0;
        end else begin
            address_q      <= address_d;
            data_q         <= data_d;
            write_enable_q <= write_enable_d;
        end
    end

    assign address      = address_q;
    assign data         = data_q;
    assign write_enable = write_enable_q;

endmodule
`default_nettype wire

// File: rtl/me_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module      : me_frame_loader
//  Description : Streams CUR_WORDS current-block words then REF_WORDS
//                reference-window words into the engine's two buffers and
//                pulses done when both are full.
//  Revision    : 1.0 - initial release
// ============================================================================
module me_frame_loader
    import me_pkg::*;
(
    input  wire                 clk,
    input  wire                 reset,
    input  wire                 start,
    me_frame_loader_if.slave    s_in,
    output logic [CUR_AW-1:0]   address_write_cur,
    output pix_word_t           data_write_cur,
    output logic                write_enable_cur,
    output logic [REF_AW-1:0]   address_write_ref,
    output pix_word_t           data_write_ref,
    output logic                write_enable_ref,
    output logic                busy,
    output logic                done
);

    localparam logic [CUR_AW-1:0] CUR_LAST = CUR_AW'(CUR_WORDS - 1);
    localparam logic [REF_AW-1:0] REF_LAST = REF_AW'(REF_WORDS - 1);

    loader_state_e     state_d, state_q;
    logic [CUR_AW-1:0] cur_cnt_d, cur_cnt_q;
    logic [REF_AW-1:0] ref_cnt_d, ref_cnt_q;
    logic              load_active;
    logic              beat;
    logic              cur_wr_en;
    logic              ref_wr_en;

    // A beat is an accepted word; ready depends on state only
    assign beat          = s_in.in_valid && load_active;
    assign s_in.in_ready = load_active;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: phases advance only on the beat carrying their last word
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start) state_d = LOAD_CUR;
            LOAD_CUR: if (beat && (cur_cnt_q == CUR_LAST)) state_d = LOAD_REF;
            LOAD_REF: if (beat && (ref_cnt_q == REF_LAST)) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        load_active = (state_q == LOAD_CUR) || (state_q == LOAD_REF);
        busy        = load_active;
        done        = (state_q == DONE);
    end

    // Word counters double as write addresses; each wraps when its phase ends
    always_comb begin
        cur_cnt_d = cur_cnt_q;
        ref_cnt_d = ref_cnt_q;
        cur_wr_en = 1'b0;
        ref_wr_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cur_cnt_d = '0;
                    ref_cnt_d = '0;
                end
            end
            LOAD_CUR: begin
                if (beat) begin
                    cur_wr_en = 1'b1;
                    cur_cnt_d = (cur_cnt_q == CUR_LAST) ? '0 : cur_cnt_q + 1'b1;
                end
            end
            LOAD_REF: begin
                if (beat) begin
                    ref_wr_en = 1'b1;
                    ref_cnt_d = (ref_cnt_q == REF_LAST) ? '0 : ref_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            cur_cnt_q <= '0;
            ref_cnt_q <= '0;
        end else begin
            cur_cnt_q <= cur_cnt_d;
            ref_cnt_q <= ref_cnt_d;
        end
    end

    me_wr_port #(.AW(CUR_AW), .DW(DATA_W)) u_cur_port (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (cur_wr_en),
        .wr_addr      (cur_cnt_q),
        .wr_data      (s_in.in_data),
        .address      (address_write_cur),
        .data         (data_write_cur),
        .write_enable (write_enable_cur)
    );

    me_wr_port #(.AW(REF_AW), .DW(DATA_W)) u_ref_port (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (ref_wr_en),
        .wr_addr      (ref_cnt_q),
        .wr_data      (s_in.in_data),
        .address      (address_write_ref),
        .data         (data_write_ref),
        .write_enable (write_enable_ref)
    );

endmodule
`default_nettype wire

// File: tb/tb_me_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_me_frame_loader
//  Description : Self-checking bench for me_frame_loader with a word-count
//                reference model and a simple engine-side buffer model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_me_frame_loader;
    import me_pkg::*;

    localparam int TOTAL = CUR_WORDS + REF_WORDS;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [CUR_AW-1:0] address_write_cur;
    pix_word_t         data_write_cur;
    logic              write_enable_cur;
    logic [REF_AW-1:0] address_write_ref;
    pix_word_t         data_write_ref;
    logic              write_enable_ref;
    logic              busy;
    logic              done;

    me_frame_loader_if u_if ();

    me_frame_loader u_dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .s_in              (u_if.slave),
        .address_write_cur (address_write_cur),
        .data_write_cur    (data_write_cur),
        .write_enable_cur  (write_enable_cur),
        .address_write_ref (address_write_ref),
        .data_write_ref    (data_write_ref),
        .write_enable_ref  (write_enable_ref),
        .busy              (busy),
        .done              (done)
    );

    always #5 clk = ~clk;

    // Engine side: buffers written on the strobe, clocked by clk
    pix_word_t cur_buf [CUR_WORDS];
    pix_word_t ref_buf [REF_WORDS];
    int        cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (write_enable_cur) cur_buf[address_write_cur] <= data_write_cur;
        if (write_enable_ref) ref_buf[address_write_ref] <= data_write_ref;
    end

    // Reference model: phase 0 idle, 1 loading, 2 done; m_k = words accepted
    int        m_phase = 0;
    int        m_k     = 0;
    bit        exp_we_cur, exp_we_ref;
    int        exp_addr_cur, exp_addr_ref;
    pix_word_t exp_data_cur, exp_data_ref;
    pix_word_t words [TOTAL];

    int checks = 0;
    int errors = 0;
    int done_count, done_cyc, start_cyc, stalls;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input bit s, input bit v, input pix_word_t d, input bit rn);
        exp_we_cur = 1'b0;
        exp_we_ref = 1'b0;
        if (!rn) begin
            m_phase = 0;
            m_k = 0;
            exp_addr_cur = 0;
            exp_data_cur = '0;
            exp_addr_ref = 0;
            exp_data_ref = '0;
        end else begin
            case (m_phase)
                0: begin
                    if (s) begin
                        m_phase = 1;
                        m_k = 0;
                    end
                end
                1: begin
                    if (v) begin
                        if (m_k < CUR_WORDS) begin
                            exp_we_cur = 1'b1;
                            exp_addr_cur = m_k;
                            exp_data_cur = d;
                        end else begin
                            exp_we_ref = 1'b1;
                            exp_addr_ref = m_k - CUR_WORDS;
                            exp_data_ref = d;
                        end
                        m_k++;
                        if (m_k == TOTAL) m_phase = 2;
                    end else begin
                        stalls++;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic compare_outputs();
        chk("busy", busy, (m_phase == 1));
        chk("done", done, (m_phase == 2));
        chk("we_cur", write_enable_cur, exp_we_cur);
        chk("we_ref", write_enable_ref, exp_we_ref);
        chk("we_overlap", (write_enable_cur && write_enable_ref), 0);
        chk("addr_cur", address_write_cur, exp_addr_cur);
        chk("data_cur", data_write_cur, exp_data_cur);
        chk("addr_ref", address_write_ref, exp_addr_ref);
        chk("data_ref", data_write_ref, exp_data_ref);
        if (done === 1'b1) begin
            done_count++;
            done_cyc = cyc;
        end
    endtask

    // One clock cycle: drive, check ready, advance model at the edge, check outputs
    task automatic step(input bit s, input bit v, input pix_word_t d, input bit rn);
        reset = rn;
        start = s;
        u_if.in_valid = v;
        u_if.in_data = d;
        #1;
        chk("in_ready", u_if.in_ready, (m_phase == 1));
        if (s && rn && (m_phase == 0)) start_cyc = cyc;
        @(posedge clk);
        model_update(s, v, d, rn);
        @(negedge clk);
        compare_outputs();
    endtask

    // mode 0: valid always high, 1: valid low every 3rd cycle, 2: random
    task automatic run_load(input int mode, input bit junk_idle);
        int        n;
        bit        v;
        bit        s;
        pix_word_t d;
        n = 0;
        done_count = 0;
        stalls = 0;
        for (int i = 0; i < TOTAL; i++)
            words[i] = (mode == 2) ? {$urandom, $urandom} : pix_word_t'(64'h1000 + i);
        if (junk_idle) step(1'b0, 1'b1, 64'hDEAD, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1);
        while ((m_phase != 0) && (n < 1000)) begin
            n++;
            case (mode)
                0:       v = 1'b1;
                1:       v = ((n % 3) != 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            // start during ref word 50 and during DONE must be ignored
            s = ((m_phase == 1) && (m_k == CUR_WORDS + 50)) || (m_phase == 2);
            d = ((m_phase == 1) && v) ? words[m_k] : {$urandom, $urandom};
            step(s, v, d, 1'b1);
        end
        chk("load_bound", (n < 1000), 1);
        chk("done_count", done_count, 1);
        chk("done_latency", done_cyc - start_cyc, 161 + stalls);
        for (int i = 0; i < CUR_WORDS; i++) chk("cur_buf", cur_buf[i], words[i]);
        for (int i = 0; i < REF_WORDS; i++) chk("ref_buf", ref_buf[i], words[CUR_WORDS + i]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        u_if.in_valid = 1'b0;
        u_if.in_data = '0;
        exp_we_cur = 1'b0;
        exp_we_ref = 1'b0;
        exp_addr_cur = 0;
        exp_addr_ref = 0;
        exp_data_cur = '0;
        exp_data_ref = '0;
        done_count = 0;
        done_cyc = 0;
        start_cyc = 0;
        stalls = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare_outputs();

        // Partial load up to cur word 10, then reset held for two cycles
        step(1'b1, 1'b0, '0, 1'b1);
        while ((m_phase == 1) && (m_k < 10)) step(1'b0, 1'b1, pix_word_t'(64'h2000 + m_k), 1'b1);
        step(1'b1, 1'b1, 64'hBAD0, 1'b0);
        step(1'b0, 1'b1, 64'hBAD1, 1'b0);

        // Full load with ignored inputs, then engine read-back
        run_load(0, 1'b1);
        chk("eng_cur_1B", cur_buf[27], 64'h101B);
        chk("eng_ref_1B", ref_buf[27], 64'h103B);

        run_load(1, 1'b0);
        run_load(2, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/me_frame_loader.md
Name: me_frame_loader

Overview:
- Streaming loader that fills the motion-estimation engine's two frame buffers before a search.
- Accepts 64-bit pixel words (8 pixels × 8 bits) on a valid/ready stream.
- Load order: 32 current-block words, then 128 reference-window words.
- Drives the engine's ref/cur buffer write ports directly; pulses done when both buffers are full so the engine can start.

Parameters:
- DATA_W, 64, width of one stream word and one buffer word
- CUR_AW, 5, current-buffer address width
- REF_AW, 7, reference-buffer address width
- CUR_WORDS, 32, words per current block; must be ≤ 2**CUR_AW
- REF_WORDS, 128, words per reference window; must be ≤ 2**REF_AW

Ports:
- clk  input  1  single system clock; all logic rises on posedge; buffer clk_write is tied to clk
- reset  input  1  synchronous, active-low reset
- start  input  1  one-cycle request to begin a load; sampled only in IDLE
- in_data  input  DATA_W  stream word
- in_valid  input  1  stream word valid
- in_ready  output  1  loader accepts a word this cycle
- address_write_cur  output  CUR_AW  current-buffer write address
- data_write_cur  output  DATA_W  current-buffer write data
- write_enable_cur  output  1  current-buffer write strobe
- address_write_ref  output  REF_AW  reference-buffer write address
- data_write_ref  output  DATA_W  reference-buffer write data
- write_enable_ref  output  1  reference-buffer write strobe
- busy  output  1  high in LOAD_CUR or LOAD_REF
- done  output  1  one-cycle pulse after the final reference word is written

Behaviour:
- Reset (reset==0 at posedge):
  - State goes to IDLE; address counters go to 0.
  - All outputs are 0 on the following cycle, including data buses.
  - Reset mid-load abandons the load; partially written buffer contents are don't-care.
- FSM states: IDLE, LOAD_CUR, LOAD_REF, DONE.
  - IDLE → LOAD_CUR on start==1; counters cleared.
  - LOAD_CUR → LOAD_REF on the beat that accepts word CUR_WORDS-1. No bubble: the next cycle may accept ref word 0.
  - LOAD_REF → DONE on the beat that accepts word REF_WORDS-1.
  - DONE → IDLE unconditionally after one cycle.
- in_ready: combinational, equals (state==LOAD_CUR || state==LOAD_REF). It must not depend on in_valid.
- Beat: in_valid && in_ready at posedge. Only beats advance counters and state. in_valid low in a load state stalls with no write.
- Write timing: outputs are registered, with one-cycle latency.
  - A beat at edge N drives write_enable_x=1 with address=word index and data=in_data during cycle N+1.
  - The write strobe is high for exactly one cycle per beat.
  - Address and data hold their last values when the strobe is low.
- Routing: write_enable_cur and write_enable_ref are never high in the same cycle. At most one is high at any time.
- Addresses:
  - Cur words go to addresses 0..CUR_WORDS-1; ref words go to addresses 0..REF_WORDS-1, both in arrival order.
  - Counters wrap to 0 when their load phase completes.
- busy: high from the cycle after start is accepted through the cycle the final beat is accepted.
- done:
  - Asserts in the cycle in DONE state, which is the same cycle as the final write_enable_ref.
  - Therefore the last reference word is committed at the edge ending the done cycle.
- start while busy or in DONE: ignored.
- in_valid in IDLE or DONE: ignored, since in_ready=0. in_data is unconstrained then.
- start and reset asserted together: reset wins.

Decomposition:
- Package me_pkg holds:
  - the constants DATA_W, CUR_AW, REF_AW, CUR_WORDS, REF_WORDS, shared with the engine;
  - the loader_state_e enum {IDLE, LOAD_CUR, LOAD_REF, DONE};
  - the typedef pix_word_t = logic [DATA_W-1:0].
- Sub-module me_wr_port: registered address/data/strobe stage, instantiated twice (cur, ref) and parameterized by address width.
- The FSM and counters stay in the top module.

Test Plan:
- Reset: hold reset=0 for 2 cycles mid-stream (cur word 10) → all outputs 0, in_ready=0; a subsequent start plus 160 beats loads cleanly from address 0.
- Full load, in_valid held high: start, then words 0x1000+i for i=0..159 → cur[i]=0x1000+i for i<32; ref[i-32]=0x1000+i; done pulses exactly once, 161 cycles after start.
- Stalls: same load with in_valid low on every 3rd cycle → identical buffer contents; no write_enable during stalled cycles; done is late by the stall count.
- Phase boundary: back-to-back beats 31 and 32 → write_enable_cur at address 31, then write_enable_ref at address 0 on the next cycle, with no overlap.
- Ignored inputs: start pulsed at ref word 50 and in_valid=1 in IDLE with data 0xDEAD → no restart, no write, address sequence unchanged.
- Engine handoff: after done, read cur addr 0x1B and ref addr 0x1B through the engine's read ports → 0x101B and 0x103B respectively.
